// File: rtl/sparsity_pkg.sv
// sparsity_pkg: state encoding and block geometry shared by the flag generator and the sequencer.
package sparsity_pkg;

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    localparam int IF_WIDTH       = 34;
    localparam int BLOCK_ROWS     = 8;
    localparam int BLOCK_SHIFT    = $clog2(BLOCK_ROWS);
    localparam int NUM_USED_BLOCK = (IF_WIDTH + BLOCK_ROWS - 1) / BLOCK_ROWS;

endpackage

// File: rtl/sparsity_flag_gen.sv
// sparsity_flag_gen: writes one zero/non-zero flag per row into the flag RAM and publishes
// the per-block valid vector once a column is complete, holding it until the consumer acks.
module sparsity_flag_gen #(
    parameter int IN_WIDTH   = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int IF_WIDTH   = 34,
    parameter int BLOCK_ROWS = 8,
    parameter int NUM_BLOCK  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  start,
    input  logic [31:0]           column,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   in_data,
    output logic                  wr_req,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_data,
    output logic [NUM_BLOCK-1:0]  valid,
    output logic [31:0]           col_idx,
    output logic                  col_done,
    input  logic                  valid_ack,
    output logic                  busy
);
    import sparsity_pkg::*;

    localparam int                    BLK_SHIFT = $clog2(BLOCK_ROWS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(IF_WIDTH - 1);

    state_t                state_q, state_d;
    logic [31:0]           col_q, col_d;
    logic [NUM_BLOCK-1:0]  accum_q, accum_d;
    logic [ADDR_WIDTH-1:0] row_cnt_q, row_cnt_d;
    logic                  wr_req_q, wr_req_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  wr_data_q, wr_data_d;
    logic [NUM_BLOCK-1:0]  valid_q, valid_d;
    logic [31:0]           col_idx_q, col_idx_d;
    logic                  col_done_q, col_done_d;

    logic                  accept;
    logic                  flag;
    logic [ADDR_WIDTH-1:0] blk;

    assign in_ready = (state_q == FILL) & clk_en;
    assign accept   = in_valid & in_ready;
    assign flag     = |in_data;
    assign blk      = row_cnt_q >> BLK_SHIFT;

    // Pulse outputs fall to 0 on a disabled cycle while every other register holds.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        accum_d    = accum_q;
        row_cnt_d  = row_cnt_q;
        wr_req_d   = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        valid_d    = valid_q;
        col_idx_d  = col_idx_q;
        col_done_d = 1'b0;
        if (clk_en) begin
            case (state_q)
                IDLE: if (start) begin
                    state_d   = FILL;
                    col_d     = column;
                    accum_d   = '0;
                    row_cnt_d = '0;
                end
                FILL: if (accept) begin
                    wr_req_d  = 1'b1;
                    wr_addr_d = row_cnt_q;
                    wr_data_d = flag;
                    accum_d   = accum_q | (NUM_BLOCK'(flag) << blk);
                    row_cnt_d = row_cnt_q + ADDR_WIDTH'(1);
                    if (row_cnt_q == LAST_ROW) begin
                        valid_d    = accum_d;
                        col_idx_d  = col_q;
                        col_done_d = 1'b1;
                        state_d    = HOLD;
                    end
                end
                HOLD: if (valid_ack) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            col_q      <= '0;
            accum_q    <= '0;
            row_cnt_q  <= '0;
            wr_req_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 1'b0;
            valid_q    <= '0;
            col_idx_q  <= '0;
            col_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            accum_q    <= accum_d;
            row_cnt_q  <= row_cnt_d;
            wr_req_q   <= wr_req_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            valid_q    <= valid_d;
            col_idx_q  <= col_idx_d;
            col_done_q <= col_done_d;
        end
    end

    assign wr_req   = wr_req_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign valid    = valid_q;
    assign col_idx  = col_idx_q;
    assign col_done = col_done_q;
    assign busy     = state_q != IDLE;

endmodule

// File: tb/tb_sparsity_flag_gen.sv
// tb_sparsity_flag_gen: directed columns with a write/publish scoreboard checked by immediate assertions.
module tb_sparsity_flag_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        start;
    logic [31:0] column;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        wr_req;
    logic [5:0]  wr_addr;
    logic        wr_data;
    logic [15:0] valid;
    logic [31:0] col_idx;
    logic        col_done;
    logic        valid_ack;
    logic        busy;

    int passed   = 0;
    int total    = 0;
    int done_cnt = 0;
    int exp_done = 0;

    logic [6:0]  exp_w[$];
    logic [47:0] exp_c[$];
    logic [6:0]  mw;
    logic [47:0] mc;

    sparsity_flag_gen dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start), .column(column),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .valid(valid), .col_idx(col_idx), .col_done(col_done),
        .valid_ack(valid_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] word(input int kind, input int r);
        case (kind)
            1: return (r == 9) ? 64'h8000_0000_0000_0000 : 64'h0;
            2: return (r == 33) ? 64'h0000_0100_0000_0000 : 64'h0;
            3: return 64'h1 << ((r * 7) % 64);
            4: return (r == 3 || r == 12 || r == 26) ? (64'h1 << r) : 64'h0;
            default: return 64'h0;
        endcase
    endfunction

    // Scoreboard side: every write and every publish must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_req) begin
                if (exp_w.size() == 0) chk("wr_unexpected", 64'(exp_w.size()), 64'd1);
                else begin
                    mw = exp_w.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(mw[6:1]));
                    chk("wr_data", 64'(wr_data), 64'(mw[0]));
                end
            end
            if (col_done) begin
                done_cnt++;
                chk("done_wr_req", 64'(wr_req), 64'd1);
                if (exp_c.size() == 0) chk("done_unexpected", 64'(exp_c.size()), 64'd1);
                else begin
                    mc = exp_c.pop_front();
                    chk("valid", 64'(valid), 64'(mc[47:32]));
                    chk("col_idx", 64'(col_idx), 64'(mc[31:0]));
                end
            end
        end
    end

    task automatic rst_chk();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_wr_req", 64'(wr_req), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_col_done", 64'(col_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_col_idx", 64'(col_idx), 64'd0);
    endtask

    task automatic run_col(input logic [31:0] col, input int kind, input bit gaps, input int stop);
        logic [15:0] ev;
        logic [63:0] w;
        int r;
        int cyc;
        bit acc;
        bit off_done;
        ev = '0;
        r = 0;
        cyc = 0;
        off_done = 0;
        @(negedge clk);
        start = 1'b1;
        column = col;
        @(posedge clk);
        while (r < stop && cyc < 3000) begin
            @(negedge clk);
            start = 1'b0;
            column = $urandom;
            if (gaps && r == 15 && !off_done) begin
                off_done = 1;
                in_valid = 1'b1;
                in_data = word(kind, r);
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    clk_en = 1'b0;
                    #1;
                    chk("clken_in_ready", 64'(in_ready), 64'd0);
                    chk("clken_busy", 64'(busy), 64'd1);
                    if (k > 0) chk("clken_wr_req", 64'(wr_req), 64'd0);
                    @(posedge clk);
                end
                cyc += 5;
                continue;
            end
            clk_en = 1'b1;
            w = word(kind, r);
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data = in_valid ? w : 64'hFFFF_FFFF_FFFF_FFFF;
            #1 acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) begin
                exp_w.push_back({6'(r), |w});
                if (w != 0) ev[r / 8] = 1'b1;
                if (r == 33) begin
                    exp_c.push_back({ev, col});
                    exp_done++;
                end
                r++;
            end
            cyc++;
        end
        chk("col_timeout", 64'(cyc < 3000), 64'd1);
    endtask

    task automatic ack_col(input logic [15:0] vexp);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("hold_in_ready", 64'(in_ready), 64'd0);
        chk("hold_busy", 64'(busy), 64'd1);
        chk("hold_valid", 64'(valid), 64'(vexp));
        valid_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_ack = 1'b0;
        #1 chk("ack_idle", 64'(busy), 64'd0);
        chk("done_count", 64'(done_cnt), 64'(exp_done));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clk_en = 1'b1;
        start = 1'b0;
        column = '0;
        in_valid = 1'b0;
        in_data = '0;
        valid_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_chk();
        @(negedge clk);
        rst_n = 1'b1;
        // in_valid while IDLE must neither be accepted nor written
        @(negedge clk);
        in_valid = 1'b1;
        in_data = '1;
        #1 chk("idle_in_ready", 64'(in_ready), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("idle_busy", 64'(busy), 64'd0);
        run_col(32'd3, 0, 1'b0, 34);
        ack_col(16'h0000);
        run_col(32'd5, 1, 1'b0, 34);
        // start pulses during HOLD are ignored
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            #1;
            chk("hold_start_ready", 64'(in_ready), 64'd0);
            chk("hold_start_busy", 64'(busy), 64'd1);
            chk("hold_start_valid", 64'(valid), 64'h0002);
            chk("hold_start_col", 64'(col_idx), 64'd5);
        end
        // start and ack together: ack wins, start dropped
        @(negedge clk);
        start = 1'b1;
        valid_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        valid_ack = 1'b0;
        #1 chk("ack_start_idle", 64'(busy), 64'd0);
        @(negedge clk);
        #1 chk("ack_start_stays_idle", 64'(busy), 64'd0);
        chk("idle_valid_kept", 64'(valid), 64'h0002);
        chk("done_count", 64'(done_cnt), 64'(exp_done));
        run_col(32'd7, 2, 1'b0, 34);
        // ack with clk_en low must not complete
        @(negedge clk);
        clk_en = 1'b0;
        valid_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1 chk("ack_clken_low", 64'(busy), 64'd1);
        clk_en = 1'b1;
        valid_ack = 1'b0;
        ack_col(16'h0010);
        run_col(32'd8, 3, 1'b0, 34);
        ack_col(16'h001F);
        run_col(32'd9, 4, 1'b0, 34);
        ack_col(16'h000B);
        run_col(32'd10, 4, 1'b1, 34);
        ack_col(16'h000B);
        // reset after row 20: partial column vanishes
        run_col(32'd11, 1, 1'b0, 21);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 rst_chk();
        chk("rst_wq_empty", 64'(exp_w.size()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_col(32'd12, 1, 1'b0, 34);
        ack_col(16'h0002);
        repeat (2) @(negedge clk);
        chk("final_done_count", 64'(done_cnt), 64'(exp_done));
        chk("final_wq_empty", 64'(exp_w.size()), 64'd0);
        chk("final_cq_empty", 64'(exp_c.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sparsity_flag_gen.md
# sparsity_flag_gen

Upstream producer for the sparsity read-address sequencer. Consumes one input-feature-map column as a stream of row words, writes one zero/non-zero flag bit per row into the 1-bit flag RAM, and builds the per-block valid vector from those rows. The sequencer uses that vector to skip all-zero blocks. Once a column is complete, the block publishes the vector and holds it until the consumer acknowledges, so the flag RAM is never overwritten while it is being read.

## Interface
Parameters:
- IN_WIDTH, 64: width of one row word; a row's flag = OR-reduce of the word.
- ADDR_WIDTH, 6: flag-RAM address width. Must satisfy IF_WIDTH <= 2^ADDR_WIDTH.
- IF_WIDTH, 34: rows per column.
- BLOCK_ROWS, 8: rows per block (BLOCK_WIDTH-2 on the consumer side).
- NUM_BLOCK, 16: width of the valid vector.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- clk_en  in  1  global clock enable; when low, all state freezes
- start  in  1  begin a new column; sampled in IDLE only
- column  in  32  column index; captured on start
- in_valid  in  1  row word present
- in_ready  out  1  row word accepted when in_valid & in_ready
- in_data  in  IN_WIDTH  row word
- wr_req  out  1  flag-RAM write strobe
- wr_addr  out  ADDR_WIDTH  flag-RAM write address (= row index)
- wr_data  out  1  flag bit
- valid  out  NUM_BLOCK  per-block non-zero vector, to the sequencer
- col_idx  out  32  column index of the published vector
- col_done  out  1  one-cycle pulse when valid/col_idx update
- valid_ack  in  1  consumer has finished with the published column
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, FILL, HOLD. All transitions qualified by clk_en.
- IDLE:
  - in_ready = 0.
  - On start: capture column, clear accum[NUM_BLOCK-1:0], set row_cnt = 0, go to FILL.
- FILL:
  - in_ready = 1.
  - Per accepted beat:
    - flag = |in_data.
    - Register wr_req = 1, wr_addr = row_cnt, wr_data = flag.
    - accum[row_cnt / BLOCK_ROWS] |= flag.
    - row_cnt++.
  - On acceptance of row IF_WIDTH-1:
    - valid <= accum with the final flag included.
    - col_idx <= captured column.
    - Pulse col_done.
    - Go to HOLD.
- HOLD:
  - in_ready = 0; valid stays stable.
  - On valid_ack: go to IDLE.
- Block bits at index >= ceil(IF_WIDTH/BLOCK_ROWS) are always 0. With the defaults, rows 32–33 form block 4 and bits 15:5 are 0.
- valid and col_idx change only at publish. They are never cleared except by reset.
- Ignored inputs:
  - start outside IDLE is ignored.
  - valid_ack outside HOLD is ignored.
  - in_valid outside FILL is ignored (no write, no accumulate).
- row_cnt is ADDR_WIDTH bits wide and is compared against IF_WIDTH-1; it never wraps within a column.
- Block index = row_cnt >> log2(BLOCK_ROWS). BLOCK_ROWS must be a power of two.

## Timing
- Reset values:
  - state = IDLE.
  - in_ready, wr_req, wr_data, col_done, busy = 0.
  - wr_addr = 0, valid = 0, col_idx = 0, accum = 0, row_cnt = 0.
- in_ready = (state == FILL) & clk_en. It is decoded from registered state, with no combinational path from in_valid.
- Write latency: wr_req/wr_addr/wr_data are asserted on the edge after acceptance, for exactly one cycle. Back-to-back beats produce back-to-back writes.
- col_done and the new valid appear on the edge after the last beat is accepted. At that edge, wr_req for row IF_WIDTH-1 is also high.
- Cycle counts:
  - Minimum column time from start to col_done: IF_WIDTH+1 cycles.
  - Minimum HOLD time: 1 cycle.
- clk_en low:
  - No state change.
  - wr_req and col_done forced to 0 that cycle.
  - Handshakes do not complete.
- start and valid_ack on the same cycle in HOLD: ack is taken, start is ignored.
- Reset mid-FILL: everything returns to reset values; a partial column is discarded with no col_done.

## Structure
- Shared package sparsity_pkg:
  - State enum {IDLE, FILL, HOLD}.
  - Constants BLOCK_ROWS, NUM_USED_BLOCK = ceil(IF_WIDTH/BLOCK_ROWS), and the log2 of BLOCK_ROWS.
  - These are shared with the sequencer.
- Single module; no sub-module is needed. The row counter and block accumulator are inline.

## Test plan
- All-zero column:
  - start, column=3, then 34 zero words.
  - Expect 34 writes with addr 0..33 and data 0, valid=16'h0000, col_idx=3, one col_done pulse.
- Single non-zero row 9 (all other rows zero):
  - Expect the write at addr 9 to carry data 1, all others 0, and valid=16'h0002.
- Tail block:
  - Only row 33 non-zero → valid=16'h0010.
  - All rows non-zero → valid=16'h001F.
- Throttling:
  - Random in_valid gaps plus clk_en low for 5 cycles mid-column.
  - Expect no missing or duplicate writes, addresses strictly increasing, and the same valid as the ungapped run.
- HOLD protocol:
  - Pulse start twice in HOLD → ignored; in_ready stays 0 and valid is stable.
  - Then assert valid_ack → IDLE next cycle. A following start begins a new column.
- Reset mid-column:
  - Assert rst_n low after row 20.
  - Expect all outputs at reset values, no col_done, and a clean full column on the next start.
